display_controller_param: RTL and testbench



---
 rtl/display_controller_param.sv | 90 +++++++++
 tb/tb_display_controller_param.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_controller_param.sv
// Parametrised N-digit hex display controller: double-buffered digits with
// per-digit blank/blink masks, a free-running blink timebase and lamp test.
module display_controller_param #(
    parameter int NUM_DIGITS = 16,
    parameter int BLINK_HALF = 13_500_000,
    parameter int CNT_W      = $clog2(BLINK_HALF)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] display_data,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    blink_restart,
    input  logic                    lamp_test,
    output logic [4*NUM_DIGITS-1:0] my_hex_data,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    blink_phase
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_HALF - 1);

    logic [4*NUM_DIGITS-1:0] r_shadowData;
    logic [NUM_DIGITS-1:0]   r_shadowBlink;
    logic [NUM_DIGITS-1:0]   r_shadowBlank;
    logic [CNT_W-1:0]        r_blinkCnt;
    logic                    r_blinkPhase;
    logic [4*NUM_DIGITS-1:0] r_hexData;
    logic [NUM_DIGITS-1:0]   r_digitEn;
    logic [4*NUM_DIGITS-1:0] w_hexData;
    logic [NUM_DIGITS-1:0]   w_digitEn;

    // Shadows only change on load, so the FSM can update inputs freely in between.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadowData  <= '0;
            r_shadowBlink <= '0;
            r_shadowBlank <= '0;
        end else if (load) begin
            r_shadowData  <= display_data;
            r_shadowBlink <= blink_mask;
            r_shadowBlank <= blank_mask;
        end
    end

    // Restart wins over a coincident wrap so the visible half always starts fresh.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blinkCnt   <= '0;
            r_blinkPhase <= 1'b1;
        end else if (blink_restart) begin
            r_blinkCnt   <= '0;
            r_blinkPhase <= 1'b1;
        end else if (r_blinkCnt == CNT_MAX) begin
            r_blinkCnt   <= '0;
            r_blinkPhase <= ~r_blinkPhase;
        end else begin
            r_blinkCnt   <= r_blinkCnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_digitEn = '0;
        w_hexData = '0;
        if (lamp_test) begin
            w_digitEn = '1;
            w_hexData = {NUM_DIGITS{4'h8}};
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                w_digitEn[i]        = ~r_shadowBlank[i] & (~r_shadowBlink[i] | r_blinkPhase);
                w_hexData[4*i +: 4] = w_digitEn[i] ? r_shadowData[4*i +: 4] : 4'h0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hexData <= '0;
            r_digitEn <= '0;
        end else begin
            r_hexData <= w_hexData;
            r_digitEn <= w_digitEn;
        end
    end

    assign my_hex_data = r_hexData;
    assign digit_en    = r_digitEn;
    assign blink_phase = r_blinkPhase;

endmodule

// File: tb/tb_display_controller_param.sv
// Testbench for display_controller_param with a cycle-level reference model
// built from elapsed-cycle arithmetic rather than a counter register.
module tb_display_controller_param;

    localparam int ND = 16;
    localparam int BH = 4;

    logic            clk = 1'b0;
    logic            resetN = 1'b0;
    logic            load = 1'b0;
    logic [4*ND-1:0] displayData = '0;
    logic [ND-1:0]   blinkMask = '0;
    logic [ND-1:0]   blankMask = '0;
    logic            blinkRestart = 1'b0;
    logic            lampTest = 1'b0;
    logic [4*ND-1:0] myHexData;
    logic [ND-1:0]   digitEn;
    logic            blinkPhase;

    display_controller_param #(.NUM_DIGITS(ND), .BLINK_HALF(BH)) dut (
        .clk           (clk),
        .reset         (resetN),
        .load          (load),
        .display_data  (displayData),
        .blink_mask    (blinkMask),
        .blank_mask    (blankMask),
        .blink_restart (blinkRestart),
        .lamp_test     (lampTest),
        .my_hex_data   (myHexData),
        .digit_en      (digitEn),
        .blink_phase   (blinkPhase)
    );

    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;

    // Reference model: shadows plus the number of edges since reset/restart.
    logic [4*ND-1:0] mData;
    logic [ND-1:0]   mBlink;
    logic [ND-1:0]   mBlank;
    int              mEdges;
    logic [4*ND-1:0] expData;
    logic [ND-1:0]   expEn;
    logic            expPhase;

    function automatic logic phaseOf(input int edges);
        return ((edges / BH) % 2) == 0;
    endfunction

    task automatic modelReset();
        mData    = '0;
        mBlink   = '0;
        mBlank   = '0;
        mEdges   = 0;
        expData  = '0;
        expEn    = '0;
        expPhase = 1'b1;
    endtask

    // Advance one clock edge; inputs must already be stable.
    task automatic cycle();
        logic curPhase;
        curPhase = phaseOf(mEdges);
        if (lampTest) begin
            expEn   = '1;
            expData = {ND{4'h8}};
        end else begin
            for (int i = 0; i < ND; i++) begin
                logic lit;
                lit = !mBlank[i] && (!mBlink[i] || curPhase);
                expEn[i]          = lit;
                expData[4*i +: 4] = lit ? mData[4*i +: 4] : 4'h0;
            end
        end
        if (load) begin
            mData  = displayData;
            mBlink = blinkMask;
            mBlank = blankMask;
        end
        if (blinkRestart) mEdges = 0;
        else              mEdges = mEdges + 1;
        expPhase = phaseOf(mEdges);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        modelReset();
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        testsRun++;
        if (myHexData !== 64'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_data got %h want 0", myHexData);
        end
        testsRun++;
        if (digitEn !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_en got %h want 0000", digitEn);
        end
        testsRun++;
        if (blinkPhase !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_phase got %b want 1", blinkPhase);
        end
        resetN = 1'b1;
        cycle();
        testsRun++;
        if (myHexData !== 64'h0 || digitEn !== 16'hFFFF) begin
            testsFailed++;
            $display("[TB] FAIL first_cycle got %h/%h want 0/ffff", myHexData, digitEn);
        end
    endtask

    task automatic test_load();
        load        = 1'b1;
        displayData = 64'h0123_4567_89AB_CDEF;
        blinkMask   = '0;
        blankMask   = '0;
        cycle();
        load = 1'b0;
        testsRun++;
        if (myHexData !== 64'h0) begin
            testsFailed++;
            $display("[TB] FAIL load_latency got %h want 0", myHexData);
        end
        cycle();
        testsRun++;
        if (myHexData !== 64'h0123_4567_89AB_CDEF || digitEn !== 16'hFFFF) begin
            testsFailed++;
            $display("[TB] FAIL load_data got %h/%h want 0123456789abcdef/ffff", myHexData, digitEn);
        end
        displayData = 64'hDEAD_BEEF_DEAD_BEEF;
        blankMask   = 16'hFFFF;
        repeat (2) cycle();
        testsRun++;
        if (myHexData !== 64'h0123_4567_89AB_CDEF || digitEn !== 16'hFFFF) begin
            testsFailed++;
            $display("[TB] FAIL load_hold got %h/%h want 0123456789abcdef/ffff", myHexData, digitEn);
        end
        blankMask = '0;
    endtask

    task automatic test_blink();
        logic prevPhase;
        int   toggles;
        load        = 1'b1;
        displayData = 64'h0123_4567_89AB_CDEF;
        blinkMask   = 16'h0001;
        cycle();
        load      = 1'b0;
        toggles   = 0;
        prevPhase = blinkPhase;
        for (int c = 0; c < 24; c++) begin
            cycle();
            if (blinkPhase !== prevPhase) toggles++;
            prevPhase = blinkPhase;
            testsRun++;
            if (blinkPhase !== expPhase || digitEn !== expEn || myHexData !== expData) begin
                testsFailed++;
                $display("[TB] FAIL blink c=%0d got %b/%h/%h want %b/%h/%h",
                         c, blinkPhase, digitEn, myHexData, expPhase, expEn, expData);
            end
            testsRun++;
            if (!((digitEn === 16'hFFFF && myHexData[3:0] === 4'hF) ||
                  (digitEn === 16'hFFFE && myHexData[3:0] === 4'h0))) begin
                testsFailed++;
                $display("[TB] FAIL blink_digit0 got en=%h d0=%h want ffff/f or fffe/0",
                         digitEn, myHexData[3:0]);
            end
        end
        testsRun++;
        if (toggles != 6) begin
            testsFailed++;
            $display("[TB] FAIL blink_toggles got %0d want 6", toggles);
        end
    endtask

    task automatic test_blank_priority();
        load      = 1'b1;
        blankMask = 16'h0003;
        blinkMask = 16'h0002;
        cycle();
        load = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            testsRun++;
            if (digitEn[1:0] !== 2'b00 || digitEn !== expEn || myHexData !== expData) begin
                testsFailed++;
                $display("[TB] FAIL blank_prio c=%0d got %h/%h want %h/%h",
                         c, digitEn, myHexData, expEn, expData);
            end
        end
    endtask

    task automatic test_restart();
        int guard;
        guard = 0;
        while ((mEdges % (2*BH)) != (2*BH - 1) && guard < 4*BH) begin
            cycle();
            guard++;
        end
        testsRun++;
        if (blinkPhase !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL restart_pre got %b want 0", blinkPhase);
        end
        blinkRestart = 1'b1;
        cycle();
        blinkRestart = 1'b0;
        testsRun++;
        if (blinkPhase !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL restart_phase got %b want 1", blinkPhase);
        end
        for (int c = 1; c <= BH; c++) begin
            cycle();
            testsRun++;
            if (blinkPhase !== ((c < BH) ? 1'b1 : 1'b0)) begin
                testsFailed++;
                $display("[TB] FAIL restart_run c=%0d got %b want %b", c, blinkPhase, (c < BH));
            end
        end
    endtask

    task automatic test_lamp();
        lampTest = 1'b1;
        cycle();
        testsRun++;
        if (myHexData !== 64'h8888_8888_8888_8888 || digitEn !== 16'hFFFF) begin
            testsFailed++;
            $display("[TB] FAIL lamp_on got %h/%h want 8888888888888888/ffff", myHexData, digitEn);
        end
        load        = 1'b1;
        displayData = 64'h1;
        blinkMask   = '0;
        blankMask   = '0;
        cycle();
        load = 1'b0;
        cycle();
        testsRun++;
        if (myHexData !== 64'h8888_8888_8888_8888) begin
            testsFailed++;
            $display("[TB] FAIL lamp_hold got %h want 8888888888888888", myHexData);
        end
        lampTest = 1'b0;
        cycle();
        testsRun++;
        if (myHexData !== 64'h1 || digitEn !== 16'hFFFF) begin
            testsFailed++;
            $display("[TB] FAIL lamp_off got %h/%h want 1/ffff", myHexData, digitEn);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            load         = ($urandom_range(0, 3) == 0);
            displayData  = {$urandom(), $urandom()};
            blinkMask    = 16'($urandom());
            blankMask    = 16'($urandom()) & 16'($urandom());
            blinkRestart = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0) lampTest = ~lampTest;
            cycle();
            testsRun++;
            if (blinkPhase !== expPhase || digitEn !== expEn || myHexData !== expData) begin
                testsFailed++;
                $display("[TB] FAIL random c=%0d got %b/%h/%h want %b/%h/%h",
                         c, blinkPhase, digitEn, myHexData, expPhase, expEn, expData);
            end
        end
        load         = 1'b0;
        blinkRestart = 1'b0;
        lampTest     = 1'b0;
    endtask

    task automatic test_async_reset();
        load        = 1'b1;
        displayData = 64'hFEDC_BA98_7654_3210;
        blinkMask   = 16'h00F0;
        blankMask   = '0;
        cycle();
        load = 1'b0;
        repeat (5) cycle();
        #2;
        resetN = 1'b0;
        #1;
        testsRun++;
        if (myHexData !== 64'h0 || digitEn !== 16'h0 || blinkPhase !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL async_reset got %h/%h/%b want 0/0/1", myHexData, digitEn, blinkPhase);
        end
        modelReset();
        @(posedge clk);
        #1;
        resetN = 1'b1;
        cycle();
        testsRun++;
        if (myHexData !== 64'h0 || digitEn !== 16'hFFFF || blinkPhase !== expPhase) begin
            testsFailed++;
            $display("[TB] FAIL post_reset got %h/%h/%b want 0/ffff/%b",
                     myHexData, digitEn, blinkPhase, expPhase);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_blink();
        test_blank_priority();
        test_restart();
        test_lamp();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
